// File: rtl/fixed_to_bcd_if.sv
// rtl/fixed_to_bcd_if.sv - handshake and data bundle between float decoder, BCD converter and display stage
interface fixed_to_bcd_if #(
    parameter int FRAC_DIGITS = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic [15:0]                in_int;
    logic [15:0]                in_frac;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_neg;
    logic [19:0]                out_int_bcd;
    logic [4*FRAC_DIGITS-1:0]   out_frac_bcd;
    logic                       busy;

    modport master (
        output in_valid, in_sign, in_int, in_frac, out_ready,
        input  in_ready, out_valid, out_neg, out_int_bcd, out_frac_bcd, busy
    );

    modport slave (
        input  in_valid, in_sign, in_int, in_frac, out_ready,
        output in_ready, out_valid, out_neg, out_int_bcd, out_frac_bcd, busy
    );
endinterface

// File: rtl/fixed_to_bcd.sv
// rtl/fixed_to_bcd.sv - sequential signed fixed-point to packed BCD converter
module fixed_to_bcd #(
    parameter int FRAC_DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fixed_to_bcd_if.slave bus
);
    localparam int FW = 4 * FRAC_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INT,
        S_FRAC,
        S_DONE
    } state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [19:0]    bcd;
    logic [15:0]    bin;
    logic [15:0]    frac_f;
    logic [FW-1:0]  frac_sr;
    logic           neg_r;
    logic           out_valid_r;
    logic           out_neg_r;
    logic [19:0]    out_int_r;
    logic [FW-1:0]  out_frac_r;

    logic [15:0]    mag;
    logic [15:0]    frac_in;
    logic [18:0]    prod;
    logic [FW-1:0]  frac_next;

    // Add-3 pass applied to every nibble before each shift of the double-dabble.
    function automatic logic [19:0] dabble(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        mag       = bus.in_sign ? (~bus.in_int + 16'd1) : bus.in_int;
        // Bit 15 of the fraction carries no weight; it is masked off at latch time.
        frac_in   = bus.in_frac & 16'h7FFF;
        prod      = 19'(frac_f) * 19'd10;
        frac_next = FW'({frac_sr, prod[18:15]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            bcd         <= 20'd0;
            bin         <= 16'd0;
            frac_f      <= 16'd0;
            frac_sr     <= '0;
            neg_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_neg_r   <= 1'b0;
            out_int_r   <= 20'd0;
            out_frac_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bin     <= mag;
                        bcd     <= 20'd0;
                        frac_f  <= frac_in;
                        frac_sr <= '0;
                        neg_r   <= bus.in_sign && (mag != 16'd0);
                        cnt     <= 5'd0;
                        state   <= S_INT;
                    end
                end
                S_INT: begin
                    {bcd, bin} <= {dabble(bcd), bin} << 1;
                    if (cnt == 5'd15) begin
                        cnt   <= 5'd0;
                        state <= S_FRAC;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_FRAC: begin
                    frac_f  <= {1'b0, prod[14:0]};
                    frac_sr <= frac_next;
                    if (cnt == 5'(FRAC_DIGITS - 1)) begin
                        cnt         <= 5'd0;
                        out_valid_r <= 1'b1;
                        out_neg_r   <= neg_r;
                        out_int_r   <= bcd;
                        out_frac_r  <= frac_next;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == S_IDLE);
    assign bus.busy         = (state == S_INT) || (state == S_FRAC);
    assign bus.out_valid    = out_valid_r;
    assign bus.out_neg      = out_neg_r;
    assign bus.out_int_bcd  = out_int_r;
    assign bus.out_frac_bcd = out_frac_r;
endmodule

// File: doc/fixed_to_bcd.md
Name: fixed_to_bcd

Overview:
- Sequential converter downstream of the float decoder stage.
- Consumes the decoder's signed 16-bit integer part and its 15-bit binary fraction, and produces packed BCD digits plus a negative flag for the display and readout stage.
- Converts the integer by iterative double-dabble at one bit per cycle, and the fraction by iterative multiply-by-10 at one digit per cycle.
- Uses valid/ready handshakes on both sides.

Parameters:
FRAC_DIGITS, 4, number of decimal fraction digits produced (legal range 1..5); conversion truncates, never rounds.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block idle and accepting
in_sign  input  1  sign bit; when 1, in_int is two's complement
in_int  input  16  integer part (two's complement if in_sign)
in_frac  input  16  fraction; bits 14:0 weight 2^-1..2^-15; bit 15 ignored
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer accepts result
out_neg  output  1  result is negative
out_int_bcd  output  20  5 BCD digits of the integer magnitude; digit 4 in [19:16]
out_frac_bcd  output  4*FRAC_DIGITS  fraction digits; first digit after the point in the MS nibble
busy  output  1  conversion in progress (INT or FRAC state)

Behaviour:
- Reset is asynchronous, active-low, and may assert at any time.
- While reset is asserted:
  - state goes to IDLE;
  - all counters and working registers are cleared;
  - out_valid=0, out_neg=0, out_int_bcd=0, out_frac_bcd=0, busy=0;
  - in_ready=1 is allowed during reset, but no input is accepted until rst_n deasserts.
- Reset asserted mid-conversion aborts the conversion with no partial output.
- States: IDLE, INT, FRAC, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, latch the input and go to INT with count=0.
  - Magnitude latched: in_sign ? (~in_int+1) : in_int, as 16-bit unsigned (0x8000 gives 32768).
  - Latched neg flag: in_sign && magnitude!=0; negative zero is not reported.
  - Latched fraction: in_frac[14:0].
- INT, 16 edges:
  - Each edge, every BCD nibble >=5 gets +3; then the {bcd20, bin16} register shifts left by 1.
  - After the 16th shift, go to FRAC with count=0.
- FRAC, FRAC_DIGITS edges:
  - Each edge computes p = f*10 (19 bits).
  - Next digit = p[18:15], appended to the fraction shift register MS-first.
  - f <= p[14:0].
  - After the last digit, go to DONE.
- DONE entry loads out_neg, out_int_bcd and out_frac_bcd, and sets out_valid=1.
- DONE hold:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - Output data registers keep the last result until the next DONE entry.
- Latency: out_valid is high after exactly 16+FRAC_DIGITS edges following the accept edge (20 with default).
- Throughput: one word per 16+FRAC_DIGITS+2 cycles minimum; no same-cycle re-accept on out_ready.
- in_ready=0 in INT, FRAC and DONE. in_valid is ignored there, and input changes have no effect after acceptance.
- busy=1 only in INT and FRAC.
- out_ready while out_valid=0 has no effect.
- BCD nibbles never exceed 9; magnitude max 65535 fits 5 digits.
- out_neg is independent of in_frac. Upstream zeroes the fraction for negatives; the block does not enforce this and converts whatever fraction it receives.

Test Plan:
- Reset: hold rst_n=0 5 cycles -> out_valid=0, busy=0, out_int_bcd=0, out_frac_bcd=0; after release, in_ready=1.
- Positive: in_sign=0, in_int=0x3039, in_frac=0x4000, in_valid 1 cycle -> out_valid high 20 edges after accept; out_int_bcd=0x12345, out_frac_bcd=0x5000, out_neg=0.
- Negative and edge values:
  - in_sign=1, in_int=0xFF85, in_frac=0 -> out_neg=1, out_int_bcd=0x00123, out_frac_bcd=0x0000.
  - in_sign=1, in_int=0x8000 -> 0x32768, out_neg=1.
  - in_sign=1, in_int=0 -> out_neg=0.
- Extremes and truncation:
  - in_int=0xFFFF, in_frac=0x7FFF -> 0x65535 / 0x9999.
  - in_frac=0x2000 -> 0x2500.
  - in_frac=0x0001 -> 0x0000.
  - in_frac=0xC000 (bit 15 set) -> 0x5000.
- Backpressure:
  - Hold out_ready=0 for 6 cycles after out_valid -> outputs stable; in_ready=0; a new in_valid word is ignored.
  - Then out_ready=1 for 1 cycle -> IDLE, in_ready=1 on the next cycle; a second word converts correctly.
- Reset mid-op: assert rst_n=0 at edge 8 of INT -> out_valid=0 and busy=0 immediately; after release, a new word (in_int=0x0007, in_frac=0x1000) -> 0x00007 / 0x1250.
